// File: rtl/replay_sample_fifo_if.sv
// Producer/consumer handshake bundle for replay_sample_fifo.
// master = the block driving pushes and pops, slave = the FIFO.
interface replay_sample_fifo_if #(
  parameter int DATA_W = 16
);
  // Write side: a push is taken on a clock edge when i_push=1 and o_full=0.
  // Read side: a pop is taken on a clock edge when i_pop=1 and o_empty=0.
  //   The word comes back on o_rdata with o_vld=1 a fixed number of cycles later.
  //   There is no backpressure on o_vld.
  logic              i_push;
  logic [DATA_W-1:0] i_wdata;
  logic              o_full;
  logic              o_ovf;
  logic              i_pop;
  logic [DATA_W-1:0] o_rdata;
  logic              o_vld;
  logic              o_empty;

  modport master (
    output i_push, i_wdata, i_pop,
    input  o_full, o_ovf, o_rdata, o_vld, o_empty
  );

  modport slave (
    input  i_push, i_wdata, i_pop,
    output o_full, o_ovf, o_rdata, o_vld, o_empty
  );
endinterface

// File: rtl/replay_sample_fifo.sv
// Single-clock sample buffer with mark/rewind replay.
// Entries from the mark onward are retained so the consumer can re-read them.
module replay_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  replay_sample_fifo_if.slave  fifo,
  input  logic                 i_flush,
  input  logic                 i_mark,
  input  logic                 i_rewind,
  output logic [AW:0]          o_count,
  output logic [AW:0]          o_avail
);

  localparam int PW = AW + 1;

  logic [PW-1:0]     mark_q, mark_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic              ovf_q, ovf_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DATA_W-1:0] data_q [RD_LAT];
  logic [DATA_W-1:0] data_d [RD_LAT];
  logic [DATA_W-1:0] mem_q  [DEPTH];

  logic [PW-1:0] count;
  logic [PW-1:0] avail;
  logic          full;
  logic          empty;
  logic          we;
  logic          re;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign count = wptr_q - mark_q;
  assign avail = wptr_q - rptr_q;
  assign full  = (count == PW'(DEPTH));
  assign empty = (wptr_q == rptr_q);

  assign we = fifo.i_push & ~full & ~i_flush;
  assign re = fifo.i_pop & ~empty & ~i_flush & ~i_rewind;

  always_comb begin
    mark_d = mark_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    ovf_d  = fifo.i_push & full & ~i_flush;

    if (we) wptr_d = wptr_q + PW'(1);

    if (i_flush) begin
      mark_d = '0;
      rptr_d = '0;
      wptr_d = '0;
    end else if (i_rewind) begin
      rptr_d = mark_q;
    end else begin
      // The mark takes the pre-pop read pointer, so a word popped now stays retained.
      if (i_mark) mark_d = rptr_q;
      if (re)     rptr_d = rptr_q + PW'(1);
    end
  end

  always_comb begin
    vld_d[0] = re;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    if (i_flush || i_rewind) vld_d = '0;

    // Data stages only move with a live valid, so o_rdata holds across squashes.
    data_d[0] = vld_d[0] ? mem_q[rptr_q[AW-1:0]] : data_q[0];
    for (int i = 1; i < RD_LAT; i++) data_d[i] = vld_d[i] ? data_q[i-1] : data_q[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mark_q <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      ovf_q  <= 1'b0;
      vld_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      mark_q <= mark_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= data_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q[AW-1:0]] <= fifo.i_wdata;
  end

  assign fifo.o_full  = full;
  assign fifo.o_empty = empty;
  assign fifo.o_ovf   = ovf_q;
  assign fifo.o_vld   = vld_q[RD_LAT-1];
  assign fifo.o_rdata = data_q[RD_LAT-1];
  assign o_count      = count;
  assign o_avail      = avail;

endmodule
